// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: self-timed bit clock, 5..DATA_BITS_MAX data bits, optional parity and 2 stop bits.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around mid-bit (default: single mid-bit sample).
module uart_rx_os #(
  parameter int DATA_BITS_MAX = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int DIV_W         = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic [DIV_W-1:0]         baud_div,
  input  logic [3:0]               data_bits,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     stop2,
  input  logic                     clr_err,
  output logic [DATA_BITS_MAX-1:0] rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(OVERSAMPLE / 2 - 2);
  localparam logic [PH_W-1:0] PH_DEC  = PH_W'(OVERSAMPLE / 2);
`else
  localparam logic [PH_W-1:0] PH_DEC  = PH_MID;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_STOP2} state_t;

  state_t                   state_q, state_d;
  logic                     rx_s1, rxs;
  logic [DIV_W-1:0]         cnt_q, div_m1;
  logic [PH_W-1:0]          phase_q;
  logic [3:0]               db_q, bit_cnt_q, db_clamped;
  logic                     pen_q, podd_q, stop2_q;
  logic [DATA_BITS_MAX-1:0] shreg_q, word;
  logic                     par_mark_q, fr_mark_q, brk_q;
  logic                     tick, dec, bit_val;
  logic                     start_det, shift_en, par_bad, fr_bad, done;

  assign div_m1     = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick       = (state_q != S_IDLE) && (cnt_q == '0);
  assign dec        = tick && (phase_q == PH_DEC);
  assign db_clamped = (data_bits < 4'd5) ? 4'd5 :
                      (data_bits > 4'(DATA_BITS_MAX)) ? 4'(DATA_BITS_MAX) : data_bits;
  // Bits enter at the MSB, so an n-bit word sits in the top n positions.
  assign word       = shreg_q >> (4'(DATA_BITS_MAX) - db_q);

`ifdef UART_RX_MAJORITY_EN
  logic vote0_q, vote1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote0_q <= 1'b1;
      vote1_q <= 1'b1;
    end else begin
      if (tick && phase_q == PH_PRE) vote0_q <= rxs;
      if (tick && phase_q == PH_MID) vote1_q <= rxs;
    end
  end
  assign bit_val = (vote0_q & vote1_q) | (vote0_q & rxs) | (vote1_q & rxs);
`else
  assign bit_val = rxs;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    shift_en  = 1'b0;
    par_bad   = 1'b0;
    fr_bad    = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_IDLE: if (!brk_q && !rxs) begin
        state_d   = S_START;
        start_det = 1'b1;
      end
      S_START: if (dec) state_d = bit_val ? S_IDLE : S_DATA;
      S_DATA: if (dec) begin
        shift_en = 1'b1;
        if (bit_cnt_q == db_q - 4'd1) state_d = pen_q ? S_PARITY : S_STOP;
      end
      S_PARITY: if (dec) begin
        par_bad = bit_val != ((^shreg_q) ^ podd_q);
        state_d = S_STOP;
      end
      S_STOP: if (dec) begin
        fr_bad = !bit_val;
        if (stop2_q) state_d = S_STOP2;
        else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_STOP2: if (dec) begin
        fr_bad  = !bit_val;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rxs        <= 1'b1;
      cnt_q      <= '0;
      phase_q    <= '0;
      db_q       <= 4'd5;
      pen_q      <= 1'b0;
      podd_q     <= 1'b0;
      stop2_q    <= 1'b0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_mark_q <= 1'b0;
      fr_mark_q  <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
      if (state_q == S_IDLE || cnt_q == '0) cnt_q <= div_m1;
      else                                  cnt_q <= cnt_q - DIV_W'(1);
      if (state_q == S_IDLE) phase_q <= '0;
      else if (tick)         phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      if (start_det) begin
        db_q       <= db_clamped;
        pen_q      <= parity_en;
        podd_q     <= parity_odd;
        stop2_q    <= stop2;
        bit_cnt_q  <= '0;
        shreg_q    <= '0;
        par_mark_q <= 1'b0;
        fr_mark_q  <= 1'b0;
      end else begin
        if (shift_en) begin
          shreg_q   <= {bit_val, shreg_q[DATA_BITS_MAX-1:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
        if (par_bad) par_mark_q <= 1'b1;
        if (fr_bad)  fr_mark_q  <= 1'b1;
      end
      // Break guard: after a low final stop, wait for the line to go high again.
      if (done)      brk_q <= !bit_val;
      else if (rxs)  brk_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (done && (!rx_valid || rx_ready)) begin
        rx_data  <= word;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      parity_err <= (parity_err & ~clr_err) | (done & par_mark_q);
      frame_err  <= (frame_err & ~clr_err) | (done & (fr_mark_q | fr_bad));
      overrun    <= (overrun & ~clr_err) | (done & rx_valid & ~rx_ready);
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx_os;
  localparam int OS  = 16;
  localparam int DBM = 8;
  localparam int DW  = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rx = 1'b1;
  logic [DW-1:0]  baud_div = 16'd4;
  logic [3:0]     data_bits = 4'd8;
  logic           parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
  logic           clr_err = 1'b0, rx_ready = 1'b1;
  logic [DBM-1:0] rx_data;
  logic           rx_valid, parity_err, frame_err, overrun;

  int n_vec = 0, n_bad = 0, cyc = 0, vld_cnt = 0, v0 = 0;
  logic [DBM-1:0] exp_q[$];
  logic exp_par = 1'b0, exp_fr = 1'b0, exp_ovr = 1'b0;

  uart_rx_os #(.DATA_BITS_MAX(DBM), .OVERSAMPLE(OS), .DIV_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .baud_div(baud_div), .data_bits(data_bits),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2), .clr_err(clr_err),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: a transfer happens on the next posedge when valid & ready
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) vld_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("spurious_word_q", 32'(exp_q.size()), 32'd1);
        else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  function automatic int eff_bits(input logic [3:0] d);
    if (d < 4'd5) return 5;
    if (int'(d) > DBM) return DBM;
    return int'(d);
  endfunction

  // driver: one frame, cycle by cycle; model updates expected word and flags
  task automatic send_frame(input logic [8:0] data, input logic [3:0] dbits, input bit pen,
                            input bit podd, input bit bad_par, input bit two_stop,
                            input logic [1:0] stop_low, input int div, input bit push,
                            input bit pulse_rdy, input int abort_at, input int glitch_at,
                            input int tail_low);
    int n, ed, bper, nb, c;
    logic [15:0] bits;
    logic [8:0] d;
    n    = eff_bits(dbits);
    ed   = (div == 0) ? 1 : div;
    bper = OS * ed;
    d    = data & ((9'd1 << n) - 9'd1);
    baud_div = DW'(div); data_bits = dbits; parity_en = pen; parity_odd = podd; stop2 = two_stop;
    bits = '0;
    for (int i = 0; i < n; i++) bits[1 + i] = d[i];
    nb = 1 + n;
    if (pen) begin bits[nb] = (^d) ^ podd ^ bad_par; nb++; end
    bits[nb] = ~stop_low[0]; nb++;
    if (two_stop) begin bits[nb] = ~stop_low[1]; nb++; end
    // edge that loads the holding register, counted from the start-bit edge
    c = 3 + ((nb - 1) * OS + OS / 2 + MAJ) * ed;
    if (abort_at < 0) begin
      if (push) exp_q.push_back(d[DBM-1:0]);
      else      exp_ovr = 1'b1;
      if (pen && bad_par) exp_par = 1'b1;
      if (stop_low[0] || (two_stop && stop_low[1])) exp_fr = 1'b1;
    end
    for (int i = 0; i < nb * bper; i++) begin
      if (abort_at >= 0 && i == abort_at) break;
      rx = bits[i / bper] ^ (glitch_at >= 0 && i >= glitch_at && i < glitch_at + ed);
      if (pulse_rdy) rx_ready = (i == c - 1);
      step();
    end
    if (pulse_rdy) rx_ready = 1'b0;
    rx = 1'b0;
    repeat (tail_low) step();
    rx = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_parity_err"}, 32'(parity_err), 32'(exp_par));
    check({tag, "_frame_err"},  32'(frame_err),  32'(exp_fr));
    check({tag, "_overrun"},    32'(overrun),    32'(exp_ovr));
  endtask

  task automatic clear_flags(input string tag);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    exp_par = 1'b0; exp_fr = 1'b0; exp_ovr = 1'b0;
    check_flags(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"},  32'(rx_data),  32'd0);
    check({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
    check_flags(tag);
  endtask

  initial begin
    logic [8:0] rd;
    logic [3:0] rb;
    bit pen, podd, bad, two;
    logic [1:0] sl;
    int div;

    rst_n = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cyc(4);

    // 8N1, div 4, 0xA5
    v0 = vld_cnt;
    send_frame(9'h0A5, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t1_valid_cycles", 32'(vld_cnt - v0), 32'd1);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    check_flags("t1");

    // 7E2 with wrong parity
    send_frame(9'h035, 4'd7, 1, 0, 1, 1, 2'b00, 4, 1, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t2_drained", 32'(exp_q.size()), 32'd0);
    check_flags("t2");
    clear_flags("t2_clr");

    // low second stop, then line held low 3 bit-times
    v0 = vld_cnt;
    send_frame(9'h0C3, 4'd8, 0, 0, 0, 1, 2'b10, 4, 1, 0, -1, -1, 3 * OS * 4);
    wait_cyc(2 * OS * 4);
    check("t3_valid_cycles", 32'(vld_cnt - v0), 32'd1);
    check("t3_drained", 32'(exp_q.size()), 32'd0);
    check_flags("t3");
    clear_flags("t3_clr");

    // overrun, then accept on the completion cycle
    rx_ready = 1'b0;
    send_frame(9'h011, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    send_frame(9'h022, 4'd8, 0, 0, 0, 0, 2'b00, 4, 0, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t4_held_data", 32'(rx_data), 32'h11);
    check_flags("t4");
    clear_flags("t4_clr");
    send_frame(9'h022, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 1, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t4_new_data", 32'(rx_data), 32'h22);
    check("t4_new_valid", 32'(rx_valid), 32'd1);
    check_flags("t4b");
    rx_ready = 1'b1;
    wait_cyc(3);
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // short low glitch on idle line
    v0 = vld_cnt;
    rx = 1'b0;
    wait_cyc((OS / 4) * 4);
    rx = 1'b1;
    wait_cyc(2 * OS * 4);
    check("t5_no_valid", 32'(vld_cnt - v0), 32'd0);
    check_flags("t5");
`ifdef UART_RX_MAJORITY_EN
    send_frame(9'h05A, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 0, -1, (OS + OS / 2) * 4, 0);
    wait_cyc(OS * 4);
    check("t5_vote_drained", 32'(exp_q.size()), 32'd0);
    check_flags("t5_vote");
`endif

    // reset in the middle of DATA with a word and a flag pending
    rx_ready = 1'b0;
    send_frame(9'h03C, 4'd8, 1, 0, 1, 0, 2'b00, 4, 1, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t6_pending_valid", 32'(rx_valid), 32'd1);
    check_flags("t6_pre");
    send_frame(9'h05A, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 0, 4 * OS * 4, -1, 0);
    rst_n = 1'b0;
    exp_q.delete();
    exp_par = 1'b0; exp_fr = 1'b0; exp_ovr = 1'b0;
    step();
    check_reset_outputs("t6_rst");
    rst_n = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(2 * OS * 4);
    send_frame(9'h05A, 4'd8, 0, 0, 0, 0, 2'b00, 4, 1, 0, -1, -1, 0);
    wait_cyc(OS * 4);
    check("t6_drained", 32'(exp_q.size()), 32'd0);
    check_flags("t6");

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      rd   = 9'($urandom);
      rb   = 4'($urandom_range(4, 10));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      bad  = 1'($urandom_range(0, 1));
      two  = 1'($urandom_range(0, 1));
      sl   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      div  = int'($urandom_range(0, 3));
      send_frame(rd, rb, pen, podd, bad, two, sl, div, 1, 0, -1, -1, 0);
      wait_cyc(2 * OS * ((div == 0) ? 1 : div));
      check("rnd_drained", 32'(exp_q.size()), 32'd0);
      check_flags("rnd");
      clear_flags("rnd_clr");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
